mac_seq_ctrl: RTL

- Sequencer that computes one dot product on the shared multiply-accumulate datapath from a single start command.
- Streams LEN operand pairs from two operand memories, feeds the accumulator, captures the final sum and pulses done.
- Sits between the register-mapped peripheral front end and the accumulator datapath.
- Replaces per-element CPU writes of data_a/data_b with one start command.

---
 rtl/mac_seq_pkg.sv | 17 +
 rtl/mac_seq_issue.sv | 78 +++++++
 rtl/mac_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared constants for the dot-product sequencer: default widths and FSM state encoding.
package mac_seq_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_LEN_W   = 11;
   localparam int DEF_MAC_LAT = 1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CLEAR   = 3'd1;
   localparam state_t ST_ISSUE   = 3'd2;
   localparam state_t ST_DRAIN   = 3'd3;
   localparam state_t ST_CAPTURE = 3'd4;

endpackage

// File: rtl/mac_seq_issue.sv
// Operand issue path: address and remaining-count counters plus the one-stage read-to-valid pipeline.
module mac_seq_issue
   import mac_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              hclk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] mem_a_rdata,
   input  logic [DATA_W-1:0] mem_b_rdata,
   output logic              mem_a_re,
   output logic [ADDR_W-1:0] mem_a_addr,
   output logic              mem_b_re,
   output logic [ADDR_W-1:0] mem_b_addr,
   output logic              last,
   output logic              empty,
   output logic [DATA_W-1:0] mac_data_a,
   output logic [DATA_W-1:0] mac_data_b,
   output logic              mac_a_valid,
   output logic              mac_b_valid
);

   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              vld_q, vld_d;

   always_comb begin
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      rem_d    = rem_q;
      if (load) begin
         addr_a_d = base_a;
         addr_b_d = base_b;
         rem_d    = len;
      end else if (en) begin
         addr_a_d = addr_a_q + ADDR_W'(1);
         addr_b_d = addr_b_q + ADDR_W'(1);
         rem_d    = rem_q - LEN_W'(1);
      end
      // en is already masked by abort upstream, so an abort also empties the pipeline
      vld_d = en;
   end

   always_ff @(posedge hclk) begin
      if (rst) begin
         addr_a_q <= '0;
         addr_b_q <= '0;
         rem_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         rem_q    <= rem_d;
         vld_q    <= vld_d;
      end
   end

   assign mem_a_re    = en;
   assign mem_b_re    = en;
   assign mem_a_addr  = addr_a_q;
   assign mem_b_addr  = addr_b_q;
   assign last        = (rem_q == LEN_W'(1));
   assign empty       = (rem_q == '0);
   // read data is registered inside the memories; gate so idle operands read as zero
   assign mac_data_a  = vld_q ? mem_a_rdata : '0;
   assign mac_data_b  = vld_q ? mem_b_rdata : '0;
   assign mac_a_valid = vld_q;
   assign mac_b_valid = vld_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: one start streams len operand pairs into the MAC and captures the sum.
// Optional MAC_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | clear accumulator and ovf, decide issue or drain
// ISSUE   | one read pair per cycle, base+i for i = 0..len-1
// DRAIN   | last pair in flight plus MAC_LAT settle cycles (down-counter)
// CAPTURE | latch mac_data_out into result, pulse done
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic              hclk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              ovf,
   output logic              mem_a_re,
   output logic [ADDR_W-1:0] mem_a_addr,
   input  logic [DATA_W-1:0] mem_a_rdata,
   output logic              mem_b_re,
   output logic [ADDR_W-1:0] mem_b_addr,
   input  logic [DATA_W-1:0] mem_b_rdata,
   output logic [DATA_W-1:0] mac_data_a,
   output logic [DATA_W-1:0] mac_data_b,
   output logic              mac_a_valid,
   output logic              mac_b_valid,
   output logic              mac_clear,
   input  logic [DATA_W-1:0] mac_data_out,
   input  logic              mac_overflow
`ifdef MAC_SEQ_CYCLE_CNT_EN
  ,output logic [31:0]       cycle_cnt
`endif
);

   localparam int DRAIN_W = $clog2(MAC_LAT + 1) + 1;

   state_t              state_q, state_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                ovf_q, ovf_d;
   logic                load;
   logic                issue_en;
   logic                last;
   logic                empty;

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      load     = 1'b0;
      issue_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               load    = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            ovf_d = 1'b0;
            // len=0 still passes through DRAIN so done latency stays len+3+MAC_LAT
            if (empty) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_W'(MAC_LAT);
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            ovf_d    = ovf_q | mac_overflow;
            issue_en = 1'b1;
            if (last) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_W'(MAC_LAT);
            end
         end
         ST_DRAIN: begin
            ovf_d = ovf_q | mac_overflow;
            if (drain_q == '0) state_d = ST_CAPTURE;
            else               drain_d = drain_q - DRAIN_W'(1);
         end
         ST_CAPTURE: begin
            ovf_d    = ovf_q | mac_overflow;
            result_d = mac_data_out;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort && state_q != ST_IDLE && state_q != ST_CAPTURE) begin
         state_d  = ST_IDLE;
         issue_en = 1'b0;
      end
   end

   always_ff @(posedge hclk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         drain_q  <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_CAPTURE);
   assign mac_clear = (state_q == ST_CLEAR);
   assign result    = result_q;
   assign ovf       = ovf_q;

   mac_seq_issue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_issue (
      .hclk        (hclk),
      .rst         (rst),
      .load        (load),
      .en          (issue_en),
      .base_a      (base_a),
      .base_b      (base_b),
      .len         (len),
      .mem_a_rdata (mem_a_rdata),
      .mem_b_rdata (mem_b_rdata),
      .mem_a_re    (mem_a_re),
      .mem_a_addr  (mem_a_addr),
      .mem_b_re    (mem_b_re),
      .mem_b_addr  (mem_b_addr),
      .last        (last),
      .empty       (empty),
      .mac_data_a  (mac_data_a),
      .mac_data_b  (mac_data_b),
      .mac_a_valid (mac_a_valid),
      .mac_b_valid (mac_b_valid)
   );

`ifdef MAC_SEQ_CYCLE_CNT_EN
   logic [31:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (load)                       cyc_d = '0;
      else if (busy && cyc_q != '1)   cyc_d = cyc_q + 32'd1;
   end

   always_ff @(posedge hclk) begin
      if (rst) cyc_q <= '0;
      else     cyc_q <= cyc_d;
   end

   assign cycle_cnt = cyc_q;
`endif

endmodule
